// File: rtl/bambu_mem_pkg.sv
// Shared types, latency defaults and request-checking helpers for the
// bambu external-memory responder.
package bambu_mem_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_RESP = 2'd2
  } ch_state_e;

  localparam int unsigned DEF_READ_DELAY  = 2;
  localparam int unsigned DEF_WRITE_DELAY = 1;

  // Number of whole bytes covered by an access size given in bits.
  function automatic int unsigned bytes_from_size(input int unsigned size_bits);
    return size_bits >> 3;
  endfunction

  // Size must be a non-zero whole number of bytes that fits the data bus.
  function automatic logic size_ok(input int unsigned size_bits,
                                   input int unsigned data_w);
    return (size_bits != 0) && ((size_bits % 8) == 0) && (size_bits <= data_w);
  endfunction

  // The access must lie completely inside the array.
  function automatic logic range_ok(input int unsigned addr,
                                    input int unsigned nbytes,
                                    input int unsigned mem_bytes);
    return (addr + nbytes) <= mem_bytes;
  endfunction

endpackage

// File: rtl/bambu_mem_channel.sv
// One memory channel: request latch, latency counter, IDLE/WAIT/RESP FSM,
// byte-lane enables and read mux. Error checks are built only when
// MEM_RESPONDER_ERR_EN is defined.
module bambu_mem_channel
  import bambu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned SIZE_W      = 7,
  parameter int unsigned MEM_BYTES   = 128,
  parameter int unsigned READ_DELAY  = DEF_READ_DELAY,
  parameter int unsigned WRITE_DELAY = DEF_WRITE_DELAY
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         oe,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [SIZE_W-1:0]            size,
  input  logic [7:0]                   mem [MEM_BYTES],
  output logic [DATA_W-1:0]            rdata,
  output logic                         data_rdy,
  output logic                         err,
  output logic                         wr_en_c,
  output logic [$clog2(MEM_BYTES)-1:0] wr_base_c,
  output logic [DATA_W/8-1:0]          wr_be_c,
  output logic [DATA_W-1:0]            wr_data_c
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned MEM_AW  = $clog2(MEM_BYTES);
  localparam int unsigned MAX_DLY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

  localparam logic [1:0] ST_IDLE = 2'(CH_IDLE);
  localparam logic [1:0] ST_WAIT = 2'(CH_WAIT);
  localparam logic [1:0] ST_RESP = 2'(CH_RESP);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, eff_addr;
  logic [SIZE_W-1:0] size_q, eff_size;
  logic [DATA_W-1:0] wdata_q, eff_wdata;
  logic              wr_q, bad_q;
  logic              idle, req, live_wr, live_bad, eff_wr, eff_bad, enter_resp;
  int unsigned       live_dly, nbytes, base;
  logic [NB-1:0]     lane_en;
  logic [DATA_W-1:0] rd_c;

  // Decode the request: in IDLE the live inputs, afterwards the latched copy.
  always_comb begin
    idle = (state_q == ST_IDLE);
    req  = oe | we;
`ifdef MEM_RESPONDER_ERR_EN
    live_wr  = we & ~oe;
    live_dly = oe ? READ_DELAY : WRITE_DELAY;
    live_bad = (oe & we)
             | !size_ok(32'(size), DATA_W)
             | !range_ok(32'(addr), bytes_from_size(32'(size)), MEM_BYTES);
`else
    live_wr  = we;
    live_dly = we ? WRITE_DELAY : READ_DELAY;
    live_bad = 1'b0;
`endif
    eff_addr  = idle ? addr     : addr_q;
    eff_size  = idle ? size     : size_q;
    eff_wdata = idle ? wdata    : wdata_q;
    eff_wr    = idle ? live_wr  : wr_q;
    eff_bad   = idle ? live_bad : bad_q;
    nbytes    = bytes_from_size(32'(eff_size));
`ifndef MEM_RESPONDER_ERR_EN
    if (nbytes > NB) nbytes = NB;
`endif
    base = 32'(eff_addr) % MEM_BYTES;
  end

  // Byte lanes: lane k maps to array byte base+k, wrapping at the array end.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign lane_en[k]       = (nbytes > k);
    assign rd_c[k*8 +: 8]   = lane_en[k] ? mem[MEM_AW'((base + k) % MEM_BYTES)] : 8'h00;
  end

  assign wr_en_c   = enter_resp & eff_wr & ~eff_bad;
  assign wr_base_c = MEM_AW'(base);
  assign wr_be_c   = lane_en;
  assign wr_data_c = eff_wdata;

  // Next-state logic; latency of 1 goes straight from IDLE to RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (live_dly <= 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(live_dly - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      bad_q    <= 1'b0;
      data_rdy <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req) begin
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= wdata;
        wr_q    <= live_wr;
        bad_q   <= live_bad;
      end
      data_rdy <= enter_resp;
      rdata    <= (enter_resp && !eff_wr && !eff_bad) ? rd_c : '0;
      err      <= err | (enter_resp & eff_bad);
    end
  end

endmodule

// File: rtl/bambu_mem_responder.sv
// External-memory responder for the HLS master port: N_CH independent
// channels over one private byte array. Define MEM_RESPONDER_ERR_EN for
// request checking and a live mem_err; otherwise addresses wrap.
module bambu_mem_responder
  import bambu_mem_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned SIZE_W      = 7,
  parameter int unsigned MEM_BYTES   = 128,
  parameter int unsigned READ_DELAY  = DEF_READ_DELAY,
  parameter int unsigned WRITE_DELAY = DEF_WRITE_DELAY
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          M_oe_ram,
  input  logic [N_CH-1:0]          M_we_ram,
  input  logic [N_CH*ADDR_W-1:0]   M_addr_ram,
  input  logic [N_CH*DATA_W-1:0]   M_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]   M_data_ram_size,
  output logic [N_CH*DATA_W-1:0]   M_Rdata_ram,
  output logic [N_CH-1:0]          M_DataRdy,
  output logic [N_CH-1:0]          mem_err
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned MEM_AW  = $clog2(MEM_BYTES);
  localparam int unsigned CH_IW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned LANE_IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned DATA_IW = $clog2(DATA_W);

  logic [7:0]        mem     [MEM_BYTES];
  logic              wr_en   [N_CH];
  logic [MEM_AW-1:0] wr_base [N_CH];
  logic [NB-1:0]     wr_be   [N_CH];
  logic [DATA_W-1:0] wr_data [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    bambu_mem_channel #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .SIZE_W      (SIZE_W),
      .MEM_BYTES   (MEM_BYTES),
      .READ_DELAY  (READ_DELAY),
      .WRITE_DELAY (WRITE_DELAY)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .oe        (M_oe_ram[c]),
      .we        (M_we_ram[c]),
      .addr      (M_addr_ram[c*ADDR_W +: ADDR_W]),
      .wdata     (M_Wdata_ram[c*DATA_W +: DATA_W]),
      .size      (M_data_ram_size[c*SIZE_W +: SIZE_W]),
      .mem       (mem),
      .rdata     (M_Rdata_ram[c*DATA_W +: DATA_W]),
      .data_rdy  (M_DataRdy[c]),
      .err       (mem_err[c]),
      .wr_en_c   (wr_en[c]),
      .wr_base_c (wr_base[c]),
      .wr_be_c   (wr_be[c]),
      .wr_data_c (wr_data[c])
    );
  end

  // Byte array write port; later (higher) channels override earlier ones.
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wr_en[CH_IW'(c)] && wr_be[CH_IW'(c)][LANE_IW'(k)]) begin
          mem[MEM_AW'((32'(wr_base[CH_IW'(c)]) + k) % MEM_BYTES)] <=
            wr_data[CH_IW'(c)][DATA_IW'(k*8) +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bambu_mem_responder.sv
// Directed bench for bambu_mem_responder with default parameters.
module tb_bambu_mem_responder;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   oe, we;
  logic [8:0]   addr_a [2];
  logic [63:0]  wd_a   [2];
  logic [6:0]   sz_a   [2];
  logic [17:0]  M_addr_ram;
  logic [127:0] M_Wdata_ram;
  logic [13:0]  M_data_ram_size;
  logic [127:0] M_Rdata_ram;
  logic [1:0]   M_DataRdy;
  logic [1:0]   mem_err;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clock = ~clock;

  assign M_addr_ram      = {addr_a[1], addr_a[0]};
  assign M_Wdata_ram     = {wd_a[1], wd_a[0]};
  assign M_data_ram_size = {sz_a[1], sz_a[0]};

  bambu_mem_responder dut (
    .clock           (clock),
    .reset           (reset),
    .M_oe_ram        (oe),
    .M_we_ram        (we),
    .M_addr_ram      (M_addr_ram),
    .M_Wdata_ram     (M_Wdata_ram),
    .M_data_ram_size (M_data_ram_size),
    .M_Rdata_ram     (M_Rdata_ram),
    .M_DataRdy       (M_DataRdy),
    .mem_err         (mem_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit ch, input logic o, input logic w,
                       input logic [8:0] a, input logic [6:0] s, input logic [63:0] d);
    oe[ch] = o; we[ch] = w; addr_a[ch] = a; sz_a[ch] = s; wd_a[ch] = d;
  endtask

  task automatic release_ch(input bit ch);
    oe[ch] = 1'b0; we[ch] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL reset_rdy: got %b want 00", M_DataRdy); end
    n_checks++; if (M_Rdata_ram !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", M_Rdata_ram); end
    n_checks++; if (mem_err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", mem_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    drive(0, 1'b0, 1'b1, 9'h10, 7'd32, 64'hDEADBEEF);
    tick();
    n_checks++; if (M_DataRdy !== 2'b01) begin n_fail++; $display("FAIL wr_strobe: got %b want 01", M_DataRdy); end
    n_checks++; if (M_Rdata_ram !== 128'h0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h want 0", M_Rdata_ram); end
    release_ch(0);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL wr_single_strobe: got %b want 00", M_DataRdy); end
    drive(0, 1'b1, 1'b0, 9'h10, 7'd32, 64'h0);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL rd_no_early: got %b want 00", M_DataRdy); end
    tick();
    n_checks++; if (M_DataRdy !== 2'b01) begin n_fail++; $display("FAIL rd_strobe: got %b want 01", M_DataRdy); end
    n_checks++; if (M_Rdata_ram[63:0] !== 64'h00000000DEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want 00000000deadbeef", M_Rdata_ram[63:0]); end
    release_ch(0);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL rd_strobe_len: got %b want 00", M_DataRdy); end
    n_checks++; if (M_Rdata_ram !== 128'h0) begin n_fail++; $display("FAIL rd_data_cleared: got %h want 0", M_Rdata_ram); end
  endtask

  task automatic test_byte_order();
    drive(0, 1'b0, 1'b1, 9'h20, 7'd64, 64'h0807060504030201);
    tick();
    n_checks++; if (M_DataRdy !== 2'b01) begin n_fail++; $display("FAIL bo_wr_strobe: got %b want 01", M_DataRdy); end
    release_ch(0);
    tick();
    drive(0, 1'b1, 1'b0, 9'h23, 7'd8, 64'h0);
    tick(); tick();
    n_checks++; if (M_Rdata_ram[63:0] !== 64'h04) begin n_fail++; $display("FAIL bo_byte23: got %h want 04", M_Rdata_ram[63:0]); end
    release_ch(0);
    tick();
    drive(0, 1'b1, 1'b0, 9'h26, 7'd16, 64'h0);
    tick(); tick();
    n_checks++; if (M_Rdata_ram[63:0] !== 64'h0807) begin n_fail++; $display("FAIL bo_half26: got %h want 0807", M_Rdata_ram[63:0]); end
    release_ch(0);
    tick();
  endtask

  task automatic test_same_byte();
    drive(0, 1'b0, 1'b1, 9'h05, 7'd8, 64'hAA);
    drive(1, 1'b0, 1'b1, 9'h05, 7'd8, 64'h55);
    tick();
    n_checks++; if (M_DataRdy !== 2'b11) begin n_fail++; $display("FAIL sb_strobes: got %b want 11", M_DataRdy); end
    release_ch(0); release_ch(1);
    tick();
    drive(0, 1'b1, 1'b0, 9'h05, 7'd8, 64'h0);
    tick(); tick();
    n_checks++; if (M_Rdata_ram[63:0] !== 64'h55) begin n_fail++; $display("FAIL sb_priority: got %h want 55", M_Rdata_ram[63:0]); end
    release_ch(0);
    tick();
  endtask

  task automatic test_read_old_value();
    drive(0, 1'b0, 1'b1, 9'h40, 7'd8, 64'h11);
    tick();
    release_ch(0);
    tick();
    drive(1, 1'b1, 1'b0, 9'h40, 7'd8, 64'h0);
    tick();
    drive(0, 1'b0, 1'b1, 9'h40, 7'd8, 64'h22);
    tick();
    n_checks++; if (M_DataRdy !== 2'b11) begin n_fail++; $display("FAIL ov_strobes: got %b want 11", M_DataRdy); end
    n_checks++; if (M_Rdata_ram[127:64] !== 64'h11) begin n_fail++; $display("FAIL ov_old_value: got %h want 11", M_Rdata_ram[127:64]); end
    release_ch(0); release_ch(1);
    tick();
    drive(1, 1'b1, 1'b0, 9'h40, 7'd8, 64'h0);
    tick(); tick();
    n_checks++; if (M_Rdata_ram[127:64] !== 64'h22) begin n_fail++; $display("FAIL ov_new_value: got %h want 22", M_Rdata_ram[127:64]); end
    release_ch(1);
    tick();
  endtask

  task automatic test_errors();
    drive(0, 1'b0, 1'b1, 9'h00, 7'd8, 64'h3A);
    drive(1, 1'b0, 1'b1, 9'h7F, 7'd8, 64'h9C);
    tick();
    release_ch(0); release_ch(1);
    tick();
    n_checks++; if (mem_err !== 2'b00) begin n_fail++; $display("FAIL err_clear_before: got %b want 00", mem_err); end
    drive(1, 1'b1, 1'b0, 9'h7F, 7'd16, 64'h0);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL edge_no_early: got %b want 00", M_DataRdy); end
    tick();
    n_checks++; if (M_DataRdy !== 2'b10) begin n_fail++; $display("FAIL edge_strobe: got %b want 10", M_DataRdy); end
`ifdef MEM_RESPONDER_ERR_EN
    n_checks++; if (M_Rdata_ram[127:64] !== 64'h0) begin n_fail++; $display("FAIL edge_rdata: got %h want 0", M_Rdata_ram[127:64]); end
    n_checks++; if (mem_err !== 2'b10) begin n_fail++; $display("FAIL edge_err: got %b want 10", mem_err); end
`else
    n_checks++; if (M_Rdata_ram[127:64] !== 64'h3A9C) begin n_fail++; $display("FAIL edge_wrap: got %h want 3a9c", M_Rdata_ram[127:64]); end
    n_checks++; if (mem_err !== 2'b00) begin n_fail++; $display("FAIL edge_err: got %b want 00", mem_err); end
`endif
    release_ch(1);
    tick(); tick();
    // Conflicting oe+we on channel 0.
    drive(0, 1'b1, 1'b1, 9'h00, 7'd8, 64'hFF);
    tick();
`ifdef MEM_RESPONDER_ERR_EN
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL both_latency: got %b want 00", M_DataRdy); end
    tick();
    n_checks++; if (M_DataRdy !== 2'b01) begin n_fail++; $display("FAIL both_strobe: got %b want 01", M_DataRdy); end
    n_checks++; if (mem_err !== 2'b11) begin n_fail++; $display("FAIL both_err_sticky: got %b want 11", mem_err); end
`else
    n_checks++; if (M_DataRdy !== 2'b01) begin n_fail++; $display("FAIL both_as_write: got %b want 01", M_DataRdy); end
    tick();
    n_checks++; if (mem_err !== 2'b00) begin n_fail++; $display("FAIL both_err: got %b want 00", mem_err); end
`endif
    release_ch(0);
    tick();
    drive(0, 1'b1, 1'b0, 9'h00, 7'd8, 64'h0);
    tick(); tick();
`ifdef MEM_RESPONDER_ERR_EN
    n_checks++; if (M_Rdata_ram[63:0] !== 64'h3A) begin n_fail++; $display("FAIL both_dropped: got %h want 3a", M_Rdata_ram[63:0]); end
`else
    n_checks++; if (M_Rdata_ram[63:0] !== 64'hFF) begin n_fail++; $display("FAIL both_written: got %h want ff", M_Rdata_ram[63:0]); end
`endif
    release_ch(0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 1'b0, 9'h10, 7'd32, 64'h0);
    tick();
    reset = 1'b1;
    release_ch(0);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL rst_no_strobe: got %b want 00", M_DataRdy); end
    n_checks++; if (M_Rdata_ram !== 128'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", M_Rdata_ram); end
    n_checks++; if (mem_err !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b want 00", mem_err); end
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 9'h10, 7'd32, 64'h0);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL rst_next_early: got %b want 00", M_DataRdy); end
    tick();
    n_checks++; if (M_DataRdy !== 2'b01) begin n_fail++; $display("FAIL rst_next_strobe: got %b want 01", M_DataRdy); end
    n_checks++; if (M_Rdata_ram[63:0] !== 64'hDEADBEEF) begin n_fail++; $display("FAIL rst_next_data: got %h want deadbeef", M_Rdata_ram[63:0]); end
    release_ch(0);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 1'b1, 1'b0, 9'h20, 7'd8, 64'h0);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL b2b_c1: got %b want 00", M_DataRdy); end
    addr_a[1] = 9'h22;
    tick();
    n_checks++; if (M_DataRdy !== 2'b10) begin n_fail++; $display("FAIL b2b_c2_strobe: got %b want 10", M_DataRdy); end
    n_checks++; if (M_Rdata_ram[127:64] !== 64'h01) begin n_fail++; $display("FAIL b2b_c2_data: got %h want 01", M_Rdata_ram[127:64]); end
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL b2b_c3: got %b want 00", M_DataRdy); end
    addr_a[1] = 9'h21;
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL b2b_c4: got %b want 00", M_DataRdy); end
    tick();
    n_checks++; if (M_DataRdy !== 2'b10) begin n_fail++; $display("FAIL b2b_c5_strobe: got %b want 10", M_DataRdy); end
    n_checks++; if (M_Rdata_ram[127:64] !== 64'h02) begin n_fail++; $display("FAIL b2b_c5_data: got %h want 02", M_Rdata_ram[127:64]); end
    release_ch(1);
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL b2b_c6: got %b want 00", M_DataRdy); end
    tick();
    n_checks++; if (M_DataRdy !== 2'b00) begin n_fail++; $display("FAIL b2b_c7: got %b want 00", M_DataRdy); end
  endtask

  initial begin
    reset = 1'b1;
    oe = 2'b00; we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_a[i] = '0; wd_a[i] = '0; sz_a[i] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_order();
    test_same_byte();
    test_read_old_value();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
